// File: rtl/act_pack_writeback.sv
// rtl/act_pack_writeback.sv - packs binarized neuron bits LSB-first into words and writes them to an activation bank
module act_pack_writeback #(
    parameter int ADDR_LEN = 10,
    parameter int PACK_W   = 8,
    parameter int SEL_LEN  = 2,
    parameter int CNT_LEN  = 11
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CNT_LEN-1:0]  layer_len,
    input  logic [SEL_LEN-1:0]  bank,
    input  logic                bit_valid,
    input  logic                bit_in,
    output logic                busy,
    output logic                mem_we,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [PACK_W-1:0]   mem_wdata,
    output logic [SEL_LEN-1:0]  mem_sel,
    output logic                done,
    output logic                ovf
);

    localparam int IDX_W = (PACK_W > 1) ? $clog2(PACK_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [CNT_LEN-1:0]  len_q, len_nx;
    logic [CNT_LEN-1:0]  count, count_nx;
    logic [PACK_W-1:0]   pack, pack_nx;
    logic [ADDR_LEN-1:0] waddr, waddr_nx;

    logic                busy_nx, we_nx, done_nx, ovf_nx;
    logic [ADDR_LEN-1:0] addr_nx;
    logic [PACK_W-1:0]   wdata_nx;
    logic [SEL_LEN-1:0]  sel_nx;

    logic               start_ok, take, last_bit, word_end;
    logic [IDX_W-1:0]   idx;
    logic [PACK_W-1:0]  word_full;

    assign start_ok  = (state == S_IDLE) && start;
    assign take      = (state == S_COLLECT) && bit_valid;
    assign idx       = count[IDX_W-1:0];
    assign last_bit  = take && ((count + 1'b1) == len_q);
    assign word_end  = take && (idx == IDX_W'(PACK_W - 1));
    // The current bit is merged in so a completed word can leave in the same edge it finishes.
    assign word_full = pack | (PACK_W'(bit_in) << idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = (layer_len == '0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (last_bit) begin
                    state_nx = S_FLUSH;
                end
            end
            S_FLUSH: state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy_nx  = (state_nx != S_IDLE);
        done_nx  = (state_nx == S_DONE);
        we_nx    = take && (word_end || last_bit);
        addr_nx  = we_nx ? waddr : mem_addr;
        wdata_nx = we_nx ? word_full : mem_wdata;
        sel_nx   = start_ok ? bank : mem_sel;
        // A stray bit coincident with an accepted start wins over the start's clear.
        if (start_ok) begin
            ovf_nx = bit_valid;
        end else begin
            ovf_nx = ovf | (bit_valid && (state != S_COLLECT));
        end

        len_nx   = len_q;
        count_nx = count;
        pack_nx  = pack;
        waddr_nx = waddr;
        if (start_ok) begin
            len_nx   = layer_len;
            count_nx = '0;
            pack_nx  = '0;
            waddr_nx = '0;
        end else if (take) begin
            count_nx = count + 1'b1;
            pack_nx  = word_end ? '0 : word_full;
            if (word_end && !last_bit) begin
                waddr_nx = waddr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q     <= '0;
            count     <= '0;
            pack      <= '0;
            waddr     <= '0;
            busy      <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_sel   <= '0;
            done      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            len_q     <= len_nx;
            count     <= count_nx;
            pack      <= pack_nx;
            waddr     <= waddr_nx;
            busy      <= busy_nx;
            mem_we    <= we_nx;
            mem_addr  <= addr_nx;
            mem_wdata <= wdata_nx;
            mem_sel   <= sel_nx;
            done      <= done_nx;
            ovf       <= ovf_nx;
        end
    end

endmodule

// File: tb/tb_act_pack_writeback.sv
// tb/tb_act_pack_writeback.sv - scoreboard bench for act_pack_writeback
module tb_act_pack_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [10:0] layer_len;
    logic [1:0]  bank;
    logic        bit_valid;
    logic        bit_in;
    logic        busy;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [1:0]  mem_sel;
    logic        done;
    logic        ovf;

    act_pack_writeback dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .layer_len (layer_len),
        .bank      (bank),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .busy      (busy),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_sel   (mem_sel),
        .done      (done),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    logic [19:0] sbq[$];
    logic [19:0] exp_wr;
    logic [7:0]  pat8;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected writes are {sel[1:0], addr[9:0], data[7:0]}.
    always @(negedge clk) begin
        if (!rst && mem_we === 1'b1) begin
            wr_cnt++;
            if (sbq.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                exp_wr = sbq.pop_front();
                check("wr_sel", 32'(mem_sel), 32'(exp_wr[19:18]));
                check("wr_addr", 32'(mem_addr), 32'(exp_wr[17:8]));
                check("wr_data", 32'(mem_wdata), 32'(exp_wr[7:0]));
            end
        end
    end

    function automatic logic get_bit(input int kind, input int i);
        case (kind)
            0:       return pat8[i % 8];
            1:       return 1'b1;
            2:       return 1'(i & 1);
            default: return 1'b0;
        endcase
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int len, input logic [1:0] bk, input logic sv);
        start     = 1'b1;
        layer_len = 11'(len);
        bank      = bk;
        bit_valid = sv;
        cycle();
        start     = 1'b0;
        bit_valid = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_sel", 32'(mem_sel), 32'(bk));
        check("start_ovf", 32'(ovf), 32'(sv));
    endtask

    task automatic drive_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        cycle();
        bit_valid = 1'b0;
    endtask

    task automatic run_layer(input int len, input logic [1:0] bk, input int kind,
                             input bit gaps, input bit flush_stray, input logic sv);
        int         w0;
        logic [7:0] acc;
        logic       b;
        w0  = wr_cnt;
        acc = '0;
        do_start(len, bk, sv);
        if (len == 0) begin
            check("zl_done", 32'(done), 32'd1);
            check("zl_we", 32'(mem_we), 32'd0);
            cycle();
            check("zl_busy_off", 32'(busy), 32'd0);
            check("zl_done_off", 32'(done), 32'd0);
            check("zl_writes", 32'(wr_cnt - w0), 32'd0);
            return;
        end
        for (int i = 0; i < len; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) cycle();
            end
            b          = get_bit(kind, i);
            acc[i % 8] = b;
            if ((i % 8) == 7 || i == len - 1) begin
                sbq.push_back({bk, 10'(i / 8), acc});
                acc = '0;
            end
            drive_bit(b);
        end
        check("flush_we", 32'(mem_we), 32'd1);
        check("flush_busy", 32'(busy), 32'd1);
        check("flush_done", 32'(done), 32'd0);
        if (flush_stray) bit_valid = 1'b1;
        cycle();
        bit_valid = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("done_we", 32'(mem_we), 32'd0);
        if (flush_stray) check("flush_stray_ovf", 32'(ovf), 32'd1);
        cycle();
        check("end_busy", 32'(busy), 32'd0);
        check("end_done", 32'(done), 32'd0);
        check("sb_empty", 32'(sbq.size()), 32'd0);
        check("word_count", 32'(wr_cnt - w0), 32'((len + 7) / 8));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_we"}, 32'(mem_we), 32'd0);
        check({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_sel"}, 32'(mem_sel), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_ovf"}, 32'(ovf), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        layer_len = '0;
        bank      = '0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        pat8      = 8'b0100_1101;
        repeat (3) cycle();
        check_all_zero("reset");
        rst = 1'b0;
        cycle();

        run_layer(8, 2'd2, 0, 1'b0, 1'b0, 1'b0);
        check("single_ovf", 32'(ovf), 32'd0);

        run_layer(20, 2'd1, 1, 1'b1, 1'b0, 1'b0);

        run_layer(1024, 2'd3, 2, 1'b0, 1'b0, 1'b0);

        bit_valid = 1'b1;
        cycle();
        bit_valid = 1'b0;
        check("stray_ovf", 32'(ovf), 32'd1);
        check("stray_busy", 32'(busy), 32'd0);
        cycle();
        run_layer(8, 2'd1, 1, 1'b0, 1'b1, 1'b0);

        do_start(8, 2'd3, 1'b0);
        for (int i = 0; i < 5; i++) drive_bit(1'b1);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        cycle();
        rst = 1'b0;
        cycle();
        check_all_zero("postrst");
        run_layer(8, 2'd3, 3, 1'b0, 1'b0, 1'b0);

        run_layer(0, 2'd2, 0, 1'b0, 1'b0, 1'b1);
        check("zl_ovf_sticky", 32'(ovf), 32'd1);

        cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/act_pack_writeback.md
# act_pack_writeback

Downstream stage of the binarized-layer compute engine. Consumes the stream of activated (sign-binarized) neuron bits the compute engine produces, packs them LSB-first into PACK_W-bit words, and writes them into a selectable activation-memory bank. The next layer then reads that bank as its input vector. Signals end-of-layer with a done pulse and flags stray input bits.

## Interface

Parameters:
- ADDR_LEN, 10: activation-memory word-address width.
- PACK_W, 8: bits packed per memory word.
- SEL_LEN, 2: bank-select width.
- CNT_LEN, 11: layer-length counter width; supported lengths are 0..1024.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle pulse that begins a layer. Sampled only in IDLE.
- layer_len  in  CNT_LEN  number of neuron bits in the layer. Latched on an accepted start.
- bank  in  SEL_LEN  destination bank. Latched on an accepted start.
- bit_valid  in  1  an activated neuron bit is present this cycle.
- bit_in  in  1  activated neuron bit; 1 = positive.
- busy  out  1  high in COLLECT, FLUSH and DONE.
- mem_we  out  1  one-cycle write strobe.
- mem_addr  out  ADDR_LEN  word address of the write.
- mem_wdata  out  PACK_W  packed word; bit k holds neuron PACK_W*mem_addr+k.
- mem_sel  out  SEL_LEN  latched bank, held stable for the whole layer.
- done  out  1  one-cycle pulse at the end of a layer.
- ovf  out  1  sticky flag: a bit_valid arrived while not in COLLECT. Cleared on an accepted start.

## Operation

- States: IDLE, COLLECT, FLUSH, DONE.
- **IDLE:**
  - On start, latch layer_len and bank, clear the bit counter, pack register and word address, and clear ovf.
  - If layer_len == 0, go to DONE. Otherwise go to COLLECT.
  - If bit_valid is asserted in IDLE, set ovf.
- **COLLECT:** each bit_valid accepts bit_in.
  - The bit is written into pack position idx = count mod PACK_W, and count is incremented.
  - If idx == PACK_W-1 and this is not the layer's last bit:
    - the completed word (including the current bit) moves to the write register;
    - mem_we pulses in the next cycle at the current word address;
    - the word address then increments and the pack register clears;
    - collection continues with no stall, so bits may arrive every cycle.
  - If this is the last bit (count+1 == layer_len):
    - the word is written in FLUSH;
    - unfilled upper bits are 0.
- **FLUSH:** mem_we=1 with the final word, then go to DONE.
- **DONE:** done=1 for one cycle, then go to IDLE.
- bit_valid in FLUSH or DONE is ignored and sets ovf.
- start outside IDLE is ignored. It does not relatch inputs and does not clear ovf.
- Word count per layer is ceil(layer_len/PACK_W). The word address never exceeds 127 at the defaults.
- mem_addr and mem_wdata hold their last values when mem_we=0. The memory accepts writes every cycle; there is no write back-pressure.

## Timing

- All outputs are registered.
- Reset values: every output is 0, and the state is IDLE. Reset mid-layer abandons the layer, and no further writes are issued.
- start accepted at edge S: busy=1 from cycle S+1.
- Intermediate word whose last bit is accepted at edge N: mem_we=1 during cycle N+1.
- Final bit accepted at edge N:
  - FLUSH write during cycle N+1;
  - done=1 during cycle N+2;
  - busy=0 from cycle N+3.
- A new start may be issued in cycle N+3.
- layer_len == 0: done=1 in cycle S+1, with no writes.
- Simultaneous bit_valid and start in IDLE: start is taken, the bit is discarded, and ovf=1. The ovf clear from start is overridden by the stray bit.

## Test plan

- **Single word:** layer_len=8, bank=2, bits 1,0,1,1,0,0,1,0 back-to-back. Expect one write: addr 0, data 0x4D, mem_sel=2. done is 2 cycles after the last bit. ovf=0.
- **Partial tail with gaps:** layer_len=20, random idle cycles between bits, all bits 1. Expect writes to addr 0, 1 and 2 with data 0xFF, 0xFF, 0x0F, then done once.
- **Full layer:** layer_len=1024, bits back-to-back with pattern bit = neuron index bit 0. Expect 128 writes, addresses 0..127, every word 0xAA, and no lost cycles.
- **Stray bit:** bit_valid=1 in IDLE. Expect no write and ovf=1. The next start clears ovf. A bit during FLUSH sets ovf again.
- **Mid-layer reset:** rst asserted after 5 of 8 bits. Expect all outputs 0 immediately. Then start with layer_len=8 and all bits 0: expect one write of 0x00 at addr 0.
- **Zero length:** start with layer_len=0. Expect done in the next cycle, no mem_we, and busy high for exactly one cycle.
